// File: rtl/cpu_control_unit_if.sv
// Bundle of the ROM fetch bus and the ALU control/result bus seen by the control unit.
interface cpu_control_unit_if #(
   parameter int OPCODE_WIDTH = 4,
   parameter int ADDR_WIDTH   = 8
);
   logic [OPCODE_WIDTH+7:0] instr;
   logic [ADDR_WIDTH-1:0]   pc;
   logic [7:0]              acc;
   logic                    cy;
   logic [OPCODE_WIDTH-1:0] opcode;
   logic [7:0]              register;
   logic                    alu_ce;
   logic                    cy_ce;
   logic                    halted;

   modport master (
      input  instr, acc, cy,
      output pc, opcode, register, alu_ce, cy_ce, halted
   );

   modport slave (
      output instr, acc, cy,
      input  pc, opcode, register, alu_ce, cy_ce, halted
   );
endinterface

// File: rtl/cpu_control_unit.sv
// Two-cycle fetch/execute sequencer for the 8-bit accumulator ALU: owns pc, IR,
// the carry flag seen by JC and a small register file used by LD/ALU ops and ST.
module cpu_control_unit #(
   parameter int OPCODE_WIDTH  = 4,
   parameter int ADDR_WIDTH    = 8,
   parameter int REG_IDX_WIDTH = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   cpu_control_unit_if.master bus
);
   localparam int NUM_REGS = 2 ** REG_IDX_WIDTH;

   localparam logic [OPCODE_WIDTH-1:0] OP_NOP = OPCODE_WIDTH'(4'h0);
   localparam logic [OPCODE_WIDTH-1:0] OP_LD  = OPCODE_WIDTH'(4'h1);
   localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(4'h2);
   localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(4'h3);
   localparam logic [OPCODE_WIDTH-1:0] OP_AND = OPCODE_WIDTH'(4'h4);
   localparam logic [OPCODE_WIDTH-1:0] OP_OR  = OPCODE_WIDTH'(4'h5);
   localparam logic [OPCODE_WIDTH-1:0] OP_XOR = OPCODE_WIDTH'(4'h6);
   localparam logic [OPCODE_WIDTH-1:0] OP_NOT = OPCODE_WIDTH'(4'h7);
   localparam logic [OPCODE_WIDTH-1:0] OP_ST  = OPCODE_WIDTH'(4'h8);
   localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(4'h9);
   localparam logic [OPCODE_WIDTH-1:0] OP_JC  = OPCODE_WIDTH'(4'hA);
   localparam logic [OPCODE_WIDTH-1:0] OP_LDI = OPCODE_WIDTH'(4'hB);
   localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(4'hF);

   typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_HALT} state_t;

   state_t                    state_reg, state_next;
   logic [ADDR_WIDTH-1:0]     pc_reg, pc_next;
   logic [OPCODE_WIDTH+7:0]   ir_reg, ir_next;
   logic                      c_flag_reg, c_flag_next;
   logic                      flag_pending_reg, flag_pending_next;
   logic                      halted_reg, halted_next;
   logic [7:0]                rf_reg [NUM_REGS];
   logic                      rf_we;

   logic [OPCODE_WIDTH-1:0]   ir_op;
   logic [7:0]                ir_opd;
   logic [REG_IDX_WIDTH-1:0]  ir_idx;

   assign ir_op  = ir_reg[OPCODE_WIDTH+7:8];
   assign ir_opd = ir_reg[7:0];
   assign ir_idx = ir_opd[REG_IDX_WIDTH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= ST_FETCH;
         pc_reg           <= '0;
         ir_reg           <= '0;
         c_flag_reg       <= 1'b0;
         flag_pending_reg <= 1'b0;
         halted_reg       <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) rf_reg[i] <= '0;
      end else begin
         state_reg        <= state_next;
         pc_reg           <= pc_next;
         ir_reg           <= ir_next;
         c_flag_reg       <= c_flag_next;
         flag_pending_reg <= flag_pending_next;
         halted_reg       <= halted_next;
         if (rf_we) rf_reg[ir_idx] <= bus.acc;
      end
   end

   always_comb begin
      state_next        = state_reg;
      pc_next           = pc_reg;
      ir_next           = ir_reg;
      c_flag_next       = c_flag_reg;
      flag_pending_next = flag_pending_reg;
      halted_next       = halted_reg;
      rf_we             = 1'b0;
      case (state_reg)
         ST_FETCH: begin
            ir_next    = bus.instr;
            state_next = ST_EXEC;
            // Carry from the previous ALU op is only valid until the ALU sees NOP.
            if (flag_pending_reg) begin
               c_flag_next       = bus.cy;
               flag_pending_next = 1'b0;
            end
         end
         ST_EXEC: begin
            state_next = ST_FETCH;
            pc_next    = pc_reg + ADDR_WIDTH'(1);
            case (ir_op)
               OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LDI:
                  flag_pending_next = 1'b1;
               OP_ST:  rf_we = 1'b1;
               OP_JMP: pc_next = ir_opd[ADDR_WIDTH-1:0];
               OP_JC:  if (c_flag_reg) pc_next = ir_opd[ADDR_WIDTH-1:0];
               OP_HLT: begin
                  pc_next     = pc_reg;
                  halted_next = 1'b1;
                  state_next  = ST_HALT;
               end
               default: ;
            endcase
         end
         ST_HALT: ;
         default: state_next = ST_FETCH;
      endcase
   end

   always_comb begin
      bus.opcode   = OP_NOP;
      bus.register = 8'h00;
      bus.alu_ce   = 1'b0;
      bus.cy_ce    = 1'b0;
      if (state_reg == ST_EXEC) begin
         case (ir_op)
            OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
               bus.opcode   = ir_op;
               bus.register = rf_reg[ir_idx];
               bus.alu_ce   = 1'b1;
               bus.cy_ce    = 1'b1;
            end
            OP_LDI: begin
               bus.opcode   = OP_LD;
               bus.register = ir_opd;
               bus.alu_ce   = 1'b1;
               bus.cy_ce    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.pc     = pc_reg;
   assign bus.halted = halted_reg;
endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Fetch/decode/sequencing stage that sits directly upstream of the 8-bit accumulator ALU.
- Addresses an external combinational program ROM and holds the instruction register and an internal 8x8 register file.
- Drives the ALU's opcode, operand, alu_ce and cy_ce inputs, and consumes the ALU's acc and cy outputs for stores and conditional jumps.
- Each instruction takes two cycles: FETCH, then EXEC.

Parameters:
- OPCODE_WIDTH, 4, opcode field width; must match the shared opcode header.
- ADDR_WIDTH, 8, program counter / ROM address width.
- REG_IDX_WIDTH, 3, register-file index width (2**REG_IDX_WIDTH registers).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  OPCODE_WIDTH+8  ROM data for address pc, valid in the same cycle; [OPCODE_WIDTH+7:8] is the opcode, [7:0] is the operand.
- pc  out  ADDR_WIDTH  program counter / ROM address.
- acc  in  8  ALU accumulator.
- cy  in  1  ALU carry.
- opcode  out  OPCODE_WIDTH  opcode to the ALU.
- register  out  8  operand to the ALU.
- alu_ce  out  1  ALU enable strobe.
- cy_ce  out  1  carry enable strobe.
- halted  out  1  high once HLT has executed.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Opcode encoding (shared header): NOP=0, LD=1, ADD=2, SUB=3, AND=4, OR=5, XOR=6, NOT=7, ST=8, JMP=9, JC=A, LDI=B, HLT=F. Undefined codes execute as NOP.
- Reset (asserted at any time, including mid-EXEC), immediately:
  - pc=0, IR=0, state=FETCH, c_flag=0, flag_pending=0, halted=0.
  - All register-file entries = 0.
  - Outputs: opcode=NOP, register=0, alu_ce=0, cy_ce=0.
- State FETCH:
  - IR <= instr at the rising edge; next state EXEC.
  - Outputs: opcode=NOP, register=0, alu_ce=0, cy_ce=0. With NOP, the ALU holds acc.
  - If flag_pending=1: c_flag <= cy at the same edge, then flag_pending <= 0. This samples the carry produced by the previous EXEC before the ALU clears it.
- State EXEC: outputs are decoded combinationally from IR and state only, with no path from instr. Let idx = IR operand[REG_IDX_WIDTH-1:0]; upper operand bits are ignored.
  - LD/ADD/SUB/AND/OR/XOR/NOT: opcode=IR opcode, register=rf[idx], alu_ce=1, cy_ce=1; flag_pending <= 1; pc <= pc+1.
  - LDI: opcode=LD, register=IR operand, alu_ce=1, cy_ce=1; flag_pending <= 1; pc <= pc+1.
  - ST: opcode=NOP, alu_ce=0; rf[idx] <= acc at the EXEC edge; pc <= pc+1.
  - JMP: opcode=NOP, alu_ce=0; pc <= operand[ADDR_WIDTH-1:0].
  - JC: opcode=NOP, alu_ce=0; pc <= operand if c_flag=1, else pc+1. c_flag is unchanged.
  - NOP/undefined: pc <= pc+1.
  - HLT: pc is held, halted <= 1, next state HALT.
  - Next state after every EXEC except HLT: FETCH.
- State HALT:
  - Outputs as in FETCH; pc frozen; halted=1.
  - Left only by reset.
- pc arithmetic: modulo 2**ADDR_WIDTH; 0xFF+1 = 0x00.
- Register-file reads:
  - The read in EXEC is combinational on rf[idx].
  - A ST followed by a LD of the same index returns the stored value, because the write completes at the ST EXEC edge.
- alu_ce and cy_ce are never high outside EXEC.
- Instruction latency: two cycles, so the pc sequence for straight-line code is 0,0,1,1,2,2,...

Test Plan:
1. Reset: pulse rst_n low mid-EXEC of ADD (alu_ce=1) -> pc, opcode and alu_ce go to 0 asynchronously; after release, the first FETCH reads address 0x00.
2. Load/store: ROM {LDI 0x05; ST r3; LDI 0x00; LD r3}, bench ALU model live -> LDI EXEC drives register=0x05, opcode=LD; rf[3]=0x05; final LD EXEC drives register=0x05.
3. Conditional jump taken: ROM {LDI 0xF0; ST r1; LDI 0x20; ADD r1; JC 0x40} -> ADD yields cy=1, c_flag=1, pc=0x40 after the JC EXEC. Repeat with LDI 0x0F instead of 0x20 -> cy=0, pc=0x05.
4. Unconditional jump: JMP 0x10 at pc 0x05 -> alu_ce=0 during EXEC; next FETCH address is 0x10; rf and c_flag unchanged.
5. Wrap: NOP at 0xFF -> next pc=0x00. Undefined opcode 0xC -> behaves as NOP, alu_ce=0.
6. Halt: HLT at 0x07 -> halted=1 and pc=0x07 for 20+ cycles, alu_ce=0 throughout; assert rst_n low -> halted=0, pc=0.
